// File: rtl/load_store_unit.sv
// Memory-access stage: one load or store per instruction over a valid/ready
// request bus with a separate single-cycle read response channel.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] RD2,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        lsu_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] tmo_cnt;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;

    logic        mem_op;
    logic        f3_legal;
    logic        reject;
    logic        tmo_expire;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rdata_shift;
    logic [31:0] rdata_ext;

    assign mem_op        = mem_read | mem_write;
    assign stall         = rst_n & mem_op & (state != DONE);
    assign bus_req_valid = (state == REQ);
    assign tmo_expire    = (tmo_cnt == TMO_LAST);

    // Classify the incoming access and build its byte lanes
    always_comb begin
        f3_legal   = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = RD2;
        if (mem_write)
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        reject = (mem_read & mem_write) | ~f3_legal |
                 ((funct3[1:0] == 2'b01) & alu_result[0]) |
                 ((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << alu_result[1:0];
                wdata_calc = {4{RD2[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << alu_result[1:0];
                wdata_calc = {2{RD2[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = RD2;
            end
        endcase
    end

    // Select the addressed lane of the response word and extend it
    always_comb begin
        rdata_shift = bus_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  rdata_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  rdata_ext = {24'd0, rdata_shift[7:0]};
            3'b101:  rdata_ext = {16'd0, rdata_shift[15:0]};
            default: rdata_ext = bus_rdata;
        endcase
    end

    // Next-state logic; completion is checked before the timeout so it wins on the limit cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_op)
                    state_next = reject ? DONE : REQ;
            end
            REQ: begin
                if (bus_req_ready)
                    state_next = bus_we ? DONE : WAIT_RSP;
                else if (tmo_expire)
                    state_next = DONE;
            end
            WAIT_RSP: begin
                if (bus_rsp_valid || tmo_expire)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Request payload, timeout counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            f3_q      <= '0;
            lane_q    <= '0;
            tmo_cnt   <= '0;
            read_data <= '0;
            lsu_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (mem_op) begin
                        if (reject) begin
                            lsu_fault <= 1'b1;
                            read_data <= '0;
                        end else begin
                            bus_we    <= mem_write;
                            bus_addr  <= {alu_result[31:2], 2'b00};
                            bus_be    <= be_calc;
                            bus_wdata <= wdata_calc;
                            f3_q      <= funct3;
                            lane_q    <= alu_result[1:0];
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (!bus_req_ready && tmo_expire) begin
                        lsu_fault <= 1'b1;
                        read_data <= '0;
                    end
                end
                WAIT_RSP: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (bus_rsp_valid)
                        read_data <= rdata_ext;
                    else if (tmo_expire) begin
                        lsu_fault <= 1'b1;
                        read_data <= '0;
                    end
                end
                DONE: begin
                    read_data <= '0;
                    lsu_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a bus responder and result scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, RD2, bus_rdata;
    logic        bus_req_ready, bus_rsp_valid;

    logic        m_stall, m_fault, m_valid, m_we;
    logic [31:0] m_rd, m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        t_stall, t_fault, t_valid, t_we;
    logic [31:0] t_rd, t_addr, t_wdata;
    logic [3:0]  t_be;

    logic        sel_to;
    logic        o_stall, o_fault, o_valid, o_we;
    logic [31:0] o_rd, o_addr, o_wdata;
    logic [3:0]  o_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .alu_result(alu_result), .RD2(RD2),
        .stall(m_stall), .read_data(m_rd), .lsu_fault(m_fault),
        .bus_req_valid(m_valid), .bus_req_ready(bus_req_ready), .bus_we(m_we),
        .bus_addr(m_addr), .bus_be(m_be), .bus_wdata(m_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .alu_result(alu_result), .RD2(RD2),
        .stall(t_stall), .read_data(t_rd), .lsu_fault(t_fault),
        .bus_req_valid(t_valid), .bus_req_ready(bus_req_ready), .bus_we(t_we),
        .bus_addr(t_addr), .bus_be(t_be), .bus_wdata(t_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    assign o_stall = sel_to ? t_stall : m_stall;
    assign o_fault = sel_to ? t_fault : m_fault;
    assign o_valid = sel_to ? t_valid : m_valid;
    assign o_we    = sel_to ? t_we    : m_we;
    assign o_rd    = sel_to ? t_rd    : m_rd;
    assign o_addr  = sel_to ? t_addr  : m_addr;
    assign o_wdata = sel_to ? t_wdata : m_wdata;
    assign o_be    = sel_to ? t_be    : m_be;

    typedef struct {
        logic        mr, mw;
        logic [2:0]  f3;
        logic [31:0] addr, rd2, rdata;
        int          rdy_dly, rsp_dly;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_rd;
        logic        exp_fault, exp_bus;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        fault;
        int          stall;
        logic        bus;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    vec_t tvecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; alu_result = '0; RD2 = '0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called just after a falling edge; acts as the bus until the access retires.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   stall_cnt = 0, req_cyc = 0, wait_cyc = 0;
        bit   accepted = 0, seen_req = 0, done = 0;
        e.rd = v.exp_rd; e.fault = v.exp_fault; e.stall = v.exp_stall; e.bus = v.exp_bus;
        sb.push_back(e);
        mem_read = v.mr; mem_write = v.mw; funct3 = v.f3; alu_result = v.addr; RD2 = v.rd2;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            #1;
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            bus_rdata     = $urandom;
            if (!o_stall) done = 1;
            else begin
                stall_cnt++;
                if (o_valid) begin
                    seen_req = 1;
                    chk("req_addr", o_addr, v.exp_addr);
                    chk("req_be", {28'd0, o_be}, {28'd0, v.exp_be});
                    chk("req_we", {31'd0, o_we}, {31'd0, v.mw});
                    if (v.mw) chk("req_wdata", o_wdata, v.exp_wdata);
                    if (req_cyc >= v.rdy_dly) begin
                        bus_req_ready = 1'b1;
                        accepted = 1;
                    end
                    req_cyc++;
                end else if (accepted && v.mr) begin
                    if (wait_cyc >= v.rsp_dly) begin
                        bus_rsp_valid = 1'b1;
                        bus_rdata = v.rdata;
                    end
                    wait_cyc++;
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_wait: stall never released at %0t", $time);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk("read_data", o_rd, e.rd);
            chk("lsu_fault", {31'd0, o_fault}, {31'd0, e.fault});
            chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            chk("bus_used", {31'd0, seen_req}, {31'd0, e.bus});
            chk("valid_in_done", {31'd0, o_valid}, 32'd0);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("rd_cleared", o_rd, 32'd0);
        chk("fault_cleared", {31'd0, o_fault}, 32'd0);
    endtask

    function automatic vec_t mk(input logic mr, mw, input logic [2:0] f3,
                                input logic [31:0] addr, rd2, rdata, input int rdy, rsp,
                                input logic [31:0] eaddr, input logic [3:0] ebe,
                                input logic [31:0] ewd, erd, input logic ef, eb, input int es);
        vec_t v;
        v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.rd2 = rd2; v.rdata = rdata;
        v.rdy_dly = rdy; v.rsp_dly = rsp; v.exp_addr = eaddr; v.exp_be = ebe;
        v.exp_wdata = ewd; v.exp_rd = erd; v.exp_fault = ef; v.exp_bus = eb; v.exp_stall = es;
        return v;
    endfunction

    initial begin
        sel_to = 1'b0;
        //              mr mw f3      addr          rd2           rdata         rdy rsp eaddr         ebe      ewdata        erd           ef eb st
        vecs.push_back(mk(1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80, 0, 1, 3));
        vecs.push_back(mk(0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        4, 0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 1, 6));
        vecs.push_back(mk(1, 0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0, 1));
        vecs.push_back(mk(1, 0, 3'b101, 32'h0000_0010, 32'h0,        32'h0000_8001, 0, 5, 32'h0000_0010, 4'b0011, 32'h0,        32'h0000_8001, 0, 1, 8));
        vecs.push_back(mk(1, 0, 3'b001, 32'h0000_0012, 32'h0,        32'h8001_0000, 1, 1, 32'h0000_0010, 4'b1100, 32'h0,        32'hFFFF_8001, 0, 1, 5));
        vecs.push_back(mk(1, 0, 3'b100, 32'h0000_1001, 32'h0,        32'h0000_F200, 0, 0, 32'h0000_1000, 4'b0010, 32'h0,        32'h0000_00F2, 0, 1, 3));
        vecs.push_back(mk(0, 1, 3'b010, 32'h0000_3000, 32'h1234_5678, 32'h0,        0, 0, 32'h0000_3000, 4'b1111, 32'h1234_5678, 32'h0,        0, 1, 2));
        vecs.push_back(mk(0, 1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h0,        2, 0, 32'h0000_3000, 4'b0010, 32'hA5A5_A5A5, 32'h0,        0, 1, 4));
        vecs.push_back(mk(1, 0, 3'b010, 32'h0000_4000, 32'h0,        32'hCAFE_F00D, 0, 2, 32'h0000_4000, 4'b1111, 32'h0,        32'hCAFE_F00D, 0, 1, 5));
        vecs.push_back(mk(0, 1, 3'b100, 32'h0000_4000, 32'h1,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0, 1));
        vecs.push_back(mk(1, 1, 3'b000, 32'h0000_4000, 32'h1,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0, 1));
        vecs.push_back(mk(0, 1, 3'b001, 32'h0000_2001, 32'h1,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0, 1));
        vecs.push_back(mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 0, 1));
        // limit of 4 cycles in REQ plus WAIT_RSP
        tvecs.push_back(mk(1, 0, 3'b010, 32'h0000_5000, 32'h0,        32'h0,        1000, 0, 32'h0000_5000, 4'b1111, 32'h0,    32'h0,        1, 1, 5));
        tvecs.push_back(mk(0, 1, 3'b010, 32'h0000_5004, 32'h1122_3344, 32'h0,        3, 0, 32'h0000_5004, 4'b1111, 32'h1122_3344, 32'h0,     0, 1, 5));
        tvecs.push_back(mk(1, 0, 3'b010, 32'h0000_5008, 32'h0,        32'h5A5A_0001, 0, 2, 32'h0000_5008, 4'b1111, 32'h0,    32'h5A5A_0001, 0, 1, 5));

        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_be", {28'd0, m_be}, 32'd0);
        chk("rst_rd", m_rd, 32'd0);
        chk("rst_fault", {31'd0, m_fault}, 32'd0);
        mem_read = 1'b1;
        #1;
        chk("rst_stall_forced", {31'd0, m_stall}, 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        sel_to = 1'b1;
        foreach (tvecs[i]) begin
            do_reset();
            run_vec(tvecs[i]);
        end
        sel_to = 1'b0;
        do_reset();

        // Reset asserted during WAIT_RSP, then a stale response after release
        mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_6000;
        @(negedge clk); #1;
        chk("rw_req_valid", {31'd0, m_valid}, 32'd1);
        bus_req_ready = 1'b1;
        @(negedge clk); #1;
        bus_req_ready = 1'b0;
        chk("rw_in_wait", {30'd0, m_valid, m_stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_stall_reset", {31'd0, m_stall}, 32'd0);
        chk("rw_rd_reset", m_rd, 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        bus_rsp_valid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk); #1;
        bus_rsp_valid = 1'b0;
        chk("stale_rd", m_rd, 32'd0);
        chk("stale_fault", {31'd0, m_fault}, 32'd0);
        chk("stale_stall", {31'd0, m_stall}, 32'd0);
        @(negedge clk);
        run_vec(vecs[0]);

        // Reset during REQ drops the request without a clock edge
        mem_write = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_7000; RD2 = 32'h5;
        @(negedge clk); #1;
        chk("rq_valid", {31'd0, m_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rq_valid_async", {31'd0, m_valid}, 32'd0);
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[6]);

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_left: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
